// File: rtl/am2940_ctrl.sv
// Am2940-style DMA address/word-count controller; counter controls are combinational, readback and done one cycle later.
// No backpressure: an instruction always wins over a same-cycle count pulse, which is dropped.
module am2940_ctrl (
  input  logic       clk,
  input  logic       res,
  input  logic [2:0] instr,
  input  logic       instr_valid,
  input  logic [7:0] data_in,
  input  logic       cnt_en,
  input  logic [7:0] addr_q,
  input  logic [7:0] wc_q,
  output logic       addr_load,
  output logic       addr_en,
  output logic       addr_up,
  output logic       wc_load,
  output logic       wc_en,
  output logic       wc_up,
  output logic [7:0] addr_data,
  output logic [7:0] wc_data,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, ACTIVE, ST_DONE} state_t;

  localparam logic [2:0] OP_WRCR   = 3'd0;
  localparam logic [2:0] OP_RDCR   = 3'd1;
  localparam logic [2:0] OP_RDWC   = 3'd2;
  localparam logic [2:0] OP_RDAC   = 3'd3;
  localparam logic [2:0] OP_REINIT = 3'd4;
  localparam logic [2:0] OP_LDAD   = 3'd5;
  localparam logic [2:0] OP_LDWC   = 3'd6;
  localparam logic [2:0] OP_ENCT   = 3'd7;

  state_t     state_q, state_d;
  logic [2:0] cr_q, cr_d;
  logic [7:0] addr_reg_q, addr_reg_d;
  logic [7:0] wc_reg_q, wc_reg_d;
  logic [7:0] data_out_q, data_out_d;
  logic       data_oe_q, data_oe_d;
  logic       done_q, done_d;

  logic [1:0] mode;
  logic [7:0] addr_step;
  logic [7:0] wc_inc;
  logic       term;

  always_comb begin
    state_d    = state_q;
    cr_d       = cr_q;
    addr_reg_d = addr_reg_q;
    wc_reg_d   = wc_reg_q;
    data_out_d = data_out_q;
    data_oe_d  = 1'b0;
    done_d     = done_q;
    addr_load  = 1'b0;
    addr_en    = 1'b0;
    wc_load    = 1'b0;
    wc_en      = 1'b0;
    addr_data  = 8'h00;
    wc_data    = 8'h00;

    mode      = cr_q[1:0];
    addr_up   = ~cr_q[2];
    wc_up     = (mode != 2'b00);
    addr_step = addr_up ? (addr_q + 8'd1) : (addr_q - 8'd1);
    wc_inc    = wc_q + 8'd1;

    // Terminal test uses the counter values before this count is applied.
    case (mode)
      2'b00:   term = (wc_q == 8'h01);
      2'b01:   term = (wc_q == 8'hFE);
      2'b10:   term = (wc_inc == wc_reg_q);
      default: term = (addr_step == wc_reg_q);
    endcase

    if (res && instr_valid) begin
      case (instr)
        OP_WRCR: cr_d = data_in[2:0];
        OP_RDCR: begin
          data_oe_d  = 1'b1;
          data_out_d = {5'b0, cr_q};
        end
        OP_RDWC: begin
          data_oe_d  = 1'b1;
          data_out_d = wc_q;
        end
        OP_RDAC: begin
          data_oe_d  = 1'b1;
          data_out_d = addr_q;
        end
        OP_REINIT: begin
          addr_load = 1'b1;
          addr_data = addr_reg_q;
          wc_load   = 1'b1;
          wc_data   = (mode == 2'b10) ? 8'h00 : wc_reg_q;
          state_d   = IDLE;
          done_d    = 1'b0;
        end
        OP_LDAD: begin
          addr_load  = 1'b1;
          addr_data  = data_in;
          addr_reg_d = data_in;
        end
        OP_LDWC: begin
          wc_load  = 1'b1;
          wc_data  = (mode == 2'b10) ? 8'h00 : data_in;
          wc_reg_d = data_in;
        end
        default: begin
          if (state_q == IDLE) state_d = ACTIVE;
        end
      endcase
    end else if (res && cnt_en && (state_q == ACTIVE)) begin
      addr_en = 1'b1;
      wc_en   = (mode != 2'b11);
      if (term) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      state_q    <= IDLE;
      cr_q       <= 3'd0;
      addr_reg_q <= 8'h00;
      wc_reg_q   <= 8'h00;
      data_out_q <= 8'h00;
      data_oe_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cr_q       <= cr_d;
      addr_reg_q <= addr_reg_d;
      wc_reg_q   <= wc_reg_d;
      data_out_q <= data_out_d;
      data_oe_q  <= data_oe_d;
      done_q     <= done_d;
    end
  end

  assign data_out = data_out_q;
  assign data_oe  = data_oe_q;
  assign done     = done_q;

endmodule

// File: tb/tb_am2940_ctrl.sv
// Directed vector bench for am2940_ctrl: inputs applied after negedge, all outputs compared mid-low-phase.
module tb_am2940_ctrl;

  logic       clk = 1'b0;
  logic       res;
  logic [2:0] instr;
  logic       instr_valid;
  logic [7:0] data_in;
  logic       cnt_en;
  logic [7:0] addr_q;
  logic [7:0] wc_q;
  logic       addr_load, addr_en, addr_up, wc_load, wc_en, wc_up;
  logic [7:0] addr_data, wc_data, data_out;
  logic       data_oe, done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  am2940_ctrl dut (
    .clk(clk), .res(res), .instr(instr), .instr_valid(instr_valid),
    .data_in(data_in), .cnt_en(cnt_en), .addr_q(addr_q), .wc_q(wc_q),
    .addr_load(addr_load), .addr_en(addr_en), .addr_up(addr_up),
    .wc_load(wc_load), .wc_en(wc_en), .wc_up(wc_up),
    .addr_data(addr_data), .wc_data(wc_data),
    .data_out(data_out), .data_oe(data_oe), .done(done)
  );

  // exp = {al, ae, au, wl, we, wu, addr_data, wc_data, data_oe, data_out, done}
  typedef struct {
    logic        r;
    logic        iv;
    logic [2:0]  ins;
    logic [7:0]  din;
    logic        cnt;
    logic [7:0]  aq;
    logic [7:0]  wq;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic iv, input logic [2:0] ins,
                              input logic [7:0] din, input logic cnt,
                              input logic [7:0] aq, input logic [7:0] wq,
                              input logic al, input logic ae, input logic au,
                              input logic wl, input logic we, input logic wu,
                              input logic [7:0] ad, input logic [7:0] wd,
                              input logic oe, input logic [7:0] dout, input logic dn);
    vec_t v;
    v.r = r; v.iv = iv; v.ins = ins; v.din = din; v.cnt = cnt; v.aq = aq; v.wq = wq;
    v.exp = {al, ae, au, wl, we, wu, ad, wd, oe, dout, dn};
    return v;
  endfunction

  task automatic run_row(input vec_t v, input string name);
    logic [31:0] act;
    @(negedge clk);
    res = v.r; instr_valid = v.iv; instr = v.ins; data_in = v.din;
    cnt_en = v.cnt; addr_q = v.aq; wc_q = v.wq;
    #2;
    act = {addr_load, addr_en, addr_up, wc_load, wc_en, wc_up,
           addr_data, wc_data, data_oe, data_out, done};
    n_checks++;
    if (act !== v.exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, v.exp);
    end
  endtask

  initial begin
    res = 1'b0; instr_valid = 1'b0; instr = 3'd0; data_in = 8'h00;
    cnt_en = 1'b0; addr_q = 8'h00; wc_q = 8'h00;
    repeat (2) @(posedge clk);

    //             r iv ins din  c aq     wq     al ae au wl we wu ad     wd     oe dout  dn
    // Reset overrides ENCT, then count in IDLE is ignored
    tbl.push_back(mk(0,1,7,8'h00,0,8'h00,8'h00, 0,0,1,0,0,0,8'h00,8'h00, 0,8'h00,0));
    tbl.push_back(mk(1,0,0,8'h00,1,8'h00,8'h00, 0,0,1,0,0,0,8'h00,8'h00, 0,8'h00,0));
    // Mode 00, word count down from 3
    tbl.push_back(mk(1,1,0,8'h00,0,8'h00,8'h00, 0,0,1,0,0,0,8'h00,8'h00, 0,8'h00,0));
    tbl.push_back(mk(1,1,5,8'h40,0,8'h00,8'h00, 1,0,1,0,0,0,8'h40,8'h00, 0,8'h00,0));
    tbl.push_back(mk(1,1,6,8'h03,0,8'h00,8'h00, 0,0,1,1,0,0,8'h00,8'h03, 0,8'h00,0));
    tbl.push_back(mk(1,1,7,8'h00,0,8'h40,8'h03, 0,0,1,0,0,0,8'h00,8'h00, 0,8'h00,0));
    tbl.push_back(mk(1,0,0,8'h00,1,8'h40,8'h03, 0,1,1,0,1,0,8'h00,8'h00, 0,8'h00,0));
    tbl.push_back(mk(1,0,0,8'h00,1,8'h41,8'h02, 0,1,1,0,1,0,8'h00,8'h00, 0,8'h00,0));
    tbl.push_back(mk(1,0,0,8'h00,1,8'h42,8'h01, 0,1,1,0,1,0,8'h00,8'h00, 0,8'h00,0));
    tbl.push_back(mk(1,0,0,8'h00,0,8'h43,8'h00, 0,0,1,0,0,0,8'h00,8'h00, 0,8'h00,1));
    // DONE ignores counts; REINIT reloads stored values
    tbl.push_back(mk(1,0,0,8'h00,1,8'h43,8'h00, 0,0,1,0,0,0,8'h00,8'h00, 0,8'h00,1));
    tbl.push_back(mk(1,1,4,8'h00,1,8'h43,8'h00, 1,0,1,1,0,0,8'h40,8'h03, 0,8'h00,1));
    tbl.push_back(mk(1,0,0,8'h00,0,8'h40,8'h03, 0,0,1,0,0,0,8'h00,8'h00, 0,8'h00,0));
    tbl.push_back(mk(1,0,0,8'h00,1,8'h40,8'h03, 0,0,1,0,0,0,8'h00,8'h00, 0,8'h00,0));
    // Mode 10, word count up from 0 to wc_reg
    tbl.push_back(mk(1,1,0,8'h02,0,8'h40,8'h03, 0,0,1,0,0,0,8'h00,8'h00, 0,8'h00,0));
    tbl.push_back(mk(1,1,6,8'h05,0,8'h40,8'h03, 0,0,1,1,0,1,8'h00,8'h00, 0,8'h00,0));
    tbl.push_back(mk(1,1,7,8'h00,0,8'h40,8'h00, 0,0,1,0,0,1,8'h00,8'h00, 0,8'h00,0));
    tbl.push_back(mk(1,0,0,8'h00,1,8'h40,8'h00, 0,1,1,0,1,1,8'h00,8'h00, 0,8'h00,0));
    tbl.push_back(mk(1,0,0,8'h00,1,8'h43,8'h03, 0,1,1,0,1,1,8'h00,8'h00, 0,8'h00,0));
    tbl.push_back(mk(1,0,0,8'h00,1,8'h44,8'h04, 0,1,1,0,1,1,8'h00,8'h00, 0,8'h00,0));
    tbl.push_back(mk(1,0,0,8'h00,0,8'h45,8'h05, 0,0,1,0,0,1,8'h00,8'h00, 0,8'h00,1));
    tbl.push_back(mk(1,1,4,8'h00,0,8'h45,8'h05, 1,0,1,1,0,1,8'h40,8'h00, 0,8'h00,1));
    tbl.push_back(mk(1,0,0,8'h00,0,8'h40,8'h00, 0,0,1,0,0,1,8'h00,8'h00, 0,8'h00,0));
    // RDCR readback: one-cycle strobe, value holds afterwards
    tbl.push_back(mk(1,1,1,8'h00,0,8'h40,8'h00, 0,0,1,0,0,1,8'h00,8'h00, 0,8'h00,0));
    tbl.push_back(mk(1,0,0,8'h00,0,8'h40,8'h00, 0,0,1,0,0,1,8'h00,8'h00, 1,8'h02,0));
    tbl.push_back(mk(1,0,0,8'h00,0,8'h40,8'h00, 0,0,1,0,0,1,8'h00,8'h00, 0,8'h02,0));
    // Mode 11 counting down on the address, compared against wc_reg
    tbl.push_back(mk(1,1,0,8'h07,0,8'h40,8'h00, 0,0,1,0,0,1,8'h00,8'h00, 0,8'h02,0));
    tbl.push_back(mk(1,1,5,8'h00,0,8'h40,8'h00, 1,0,0,0,0,1,8'h00,8'h00, 0,8'h02,0));
    tbl.push_back(mk(1,1,6,8'hFE,0,8'h00,8'h00, 0,0,0,1,0,1,8'h00,8'hFE, 0,8'h02,0));
    tbl.push_back(mk(1,1,7,8'h00,0,8'h00,8'hFE, 0,0,0,0,0,1,8'h00,8'h00, 0,8'h02,0));
    tbl.push_back(mk(1,0,0,8'h00,1,8'h00,8'hFE, 0,1,0,0,0,1,8'h00,8'h00, 0,8'h02,0));
    tbl.push_back(mk(1,0,0,8'h00,1,8'hFF,8'hFE, 0,1,0,0,0,1,8'h00,8'h00, 0,8'h02,0));
    tbl.push_back(mk(1,0,0,8'h00,0,8'hFE,8'hFE, 0,0,0,0,0,1,8'h00,8'h00, 0,8'h02,1));
    // Reset while in DONE gates all controls, then back to IDLE
    tbl.push_back(mk(0,0,0,8'h00,1,8'hFE,8'hFE, 0,0,0,0,0,1,8'h00,8'h00, 0,8'h02,1));
    tbl.push_back(mk(1,0,0,8'h00,1,8'hFE,8'hFE, 0,0,1,0,0,0,8'h00,8'h00, 0,8'h00,0));
    // Instruction beats a same-cycle count; readback of address and word count
    tbl.push_back(mk(1,1,7,8'h00,0,8'h10,8'h20, 0,0,1,0,0,0,8'h00,8'h00, 0,8'h00,0));
    tbl.push_back(mk(1,1,5,8'h77,1,8'h10,8'h20, 1,0,1,0,0,0,8'h77,8'h00, 0,8'h00,0));
    tbl.push_back(mk(1,1,3,8'h00,0,8'h77,8'h20, 0,0,1,0,0,0,8'h00,8'h00, 0,8'h00,0));
    tbl.push_back(mk(1,0,0,8'h00,0,8'h78,8'h20, 0,0,1,0,0,0,8'h00,8'h00, 1,8'h77,0));
    tbl.push_back(mk(1,0,0,8'h00,0,8'h78,8'h20, 0,0,1,0,0,0,8'h00,8'h00, 0,8'h77,0));
    tbl.push_back(mk(1,1,2,8'h00,0,8'h78,8'h5A, 0,0,1,0,0,0,8'h00,8'h00, 0,8'h77,0));
    tbl.push_back(mk(1,0,0,8'h00,0,8'h78,8'h5B, 0,0,1,0,0,0,8'h00,8'h00, 1,8'h5A,0));

    foreach (tbl[i]) run_row(tbl[i], $sformatf("row%0d", i));

    // Mode 01: word count rising through F0..FD stays live, FE is terminal
    run_row(mk(0,0,0,8'h00,0,8'h00,8'h00, 0,0,1,0,0,0,8'h00,8'h00, 0,8'h5A,0), "m01_rst");
    run_row(mk(1,1,0,8'h01,0,8'h00,8'h00, 0,0,1,0,0,0,8'h00,8'h00, 0,8'h00,0), "m01_wrcr");
    run_row(mk(1,1,6,8'h10,0,8'h00,8'h00, 0,0,1,1,0,1,8'h00,8'h10, 0,8'h00,0), "m01_ldwc");
    run_row(mk(1,1,7,8'h00,0,8'h00,8'h00, 0,0,1,0,0,1,8'h00,8'h00, 0,8'h00,0), "m01_enct");
    for (int w = 8'hF0; w <= 8'hFE; w++)
      run_row(mk(1,0,0,8'h00,1,8'h00,w[7:0], 0,1,1,0,1,1,8'h00,8'h00, 0,8'h00,0),
              $sformatf("m01_cnt_%h", w[7:0]));
    run_row(mk(1,0,0,8'h00,0,8'h00,8'hFF, 0,0,1,0,0,1,8'h00,8'h00, 0,8'h00,1), "m01_done");

    // Mode 11 counting up: address FF wraps to 00 and matches wc_reg=00
    run_row(mk(0,0,0,8'h00,0,8'h00,8'h00, 0,0,1,0,0,1,8'h00,8'h00, 0,8'h00,1), "wrap_rst");
    run_row(mk(1,1,0,8'h03,0,8'h00,8'h00, 0,0,1,0,0,0,8'h00,8'h00, 0,8'h00,0), "wrap_wrcr");
    run_row(mk(1,1,6,8'h00,0,8'h00,8'h00, 0,0,1,1,0,1,8'h00,8'h00, 0,8'h00,0), "wrap_ldwc");
    run_row(mk(1,1,7,8'h00,0,8'h00,8'h00, 0,0,1,0,0,1,8'h00,8'h00, 0,8'h00,0), "wrap_enct");
    run_row(mk(1,0,0,8'h00,1,8'hFE,8'h00, 0,1,1,0,0,1,8'h00,8'h00, 0,8'h00,0), "wrap_fe");
    run_row(mk(1,0,0,8'h00,0,8'hFF,8'h00, 0,0,1,0,0,1,8'h00,8'h00, 0,8'h00,0), "wrap_gap");
    run_row(mk(1,0,0,8'h00,1,8'hFF,8'h00, 0,1,1,0,0,1,8'h00,8'h00, 0,8'h00,0), "wrap_ff");
    run_row(mk(1,0,0,8'h00,1,8'h00,8'h00, 0,0,1,0,0,1,8'h00,8'h00, 0,8'h00,1), "wrap_done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/am2940_ctrl.md
AM2940_CTRL -- requirements
Module: am2940_ctrl

Interface
REQ-001 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port res  input  1  reset: synchronous, active-low; sampled only on rising clk.
REQ-003 SHALL have port instr  input  3  instruction code, valid only when instr_valid=1.
REQ-004 SHALL have port instr_valid  input  1  instruction strobe; one instruction accepted per asserted cycle.
REQ-005 SHALL have port data_in  input  8  operand bus for control, address and word-count writes.
REQ-006 SHALL have port cnt_en  input  1  transfer-complete pulse; one pulse is one count request.
REQ-007 SHALL have port addr_q  input  8  current address-counter value from the counter-slice chain.
REQ-008 SHALL have port wc_q  input  8  current word-counter value from the counter-slice chain.
REQ-009 SHALL have ports addr_load, addr_en, addr_up  output  1 each  address-counter controls.
REQ-010 SHALL have ports wc_load, wc_en, wc_up  output  1 each  word-counter controls.
REQ-011 SHALL have ports addr_data, wc_data  output  8 each  counter load values.
REQ-012 SHALL have ports data_out  output  8 and data_oe  output  1  registered readback.
REQ-013 SHALL have port done  output  1  registered terminal-count flag.

Function
REQ-014 SHALL hold internal registers cr[2:0], addr_reg[7:0], wc_reg[7:0] and state {IDLE, ACTIVE, DONE}; mode = cr[1:0].
REQ-015 SHALL decode instr on instr_valid: 0 WRCR, 1 RDCR, 2 RDWC, 3 RDAC, 4 REINIT, 5 LDAD, 6 LDWC, 7 ENCT.
REQ-016 WRCR SHALL set cr <= data_in[2:0] at the edge; allowed in any state.
REQ-017 RDCR/RDWC/RDAC SHALL drive data_out = {5'b0,cr} / wc_q / addr_q and data_oe=1 in the following cycle only; data_oe=0 otherwise, data_out holds its last value.
REQ-018 LDAD SHALL, in the same cycle (combinational), assert addr_load=1, addr_data=data_in; addr_reg <= data_in at the edge.
REQ-019 LDWC SHALL, in the same cycle, assert wc_load=1, wc_data = (mode==2'b10 ? 8'h00 : data_in); wc_reg <= data_in at the edge.
REQ-020 REINIT SHALL, in the same cycle, assert addr_load=1 with addr_data=addr_reg and wc_load=1 with wc_data = (mode==2'b10 ? 8'h00 : wc_reg); next state IDLE, done <= 0.
REQ-021 ENCT SHALL move IDLE->ACTIVE; ACTIVE and DONE unchanged.
REQ-022 addr_up SHALL equal ~cr[2]; wc_up SHALL equal (mode != 2'b00); both combinational, always driven.
REQ-023 Count acceptance: cnt_en=1, state ACTIVE, instr_valid=0 -> addr_en=1 and wc_en = (mode != 2'b11), same cycle; otherwise addr_en=wc_en=0.
REQ-024 A valid instruction in the same cycle as cnt_en SHALL take priority; that count is dropped, not deferred.
REQ-025 Terminal test on each accepted count, using pre-count values: mode 00 wc_q==8'h01; mode 01 wc_q==8'hFE; mode 10 (wc_q+1)[7:0]==wc_reg; mode 11 (addr_q +/-1 per addr_up)[7:0]==wc_reg.
REQ-026 On terminal test true: state ACTIVE->DONE and done=1 from the next cycle; DONE holds, cnt_en ignored, until REINIT or reset.
REQ-027 All 8-bit arithmetic SHALL wrap modulo 256 (8'hFF+1=8'h00, 8'h00-1=8'hFF).
REQ-028 load, en and data outputs SHALL be 0 whenever res=0 or no qualifying event.

Reset
REQ-029 res=0 at a rising edge SHALL set cr=0, addr_reg=0, wc_reg=0, state IDLE, done=0, data_oe=0, data_out=8'h00, overriding any instruction or count that cycle.
REQ-030 Reset mid-transfer (ACTIVE or DONE) SHALL abort to IDLE; ENCT is required before counting resumes.

Verification
REQ-031 Reset with instr_valid=1, instr=7 -> after edge state IDLE, done=0, data_oe=0; subsequent cnt_en gives addr_en=0.
REQ-032 WRCR 8'h00, LDAD 8'h40, LDWC 8'h03, ENCT, 3 cnt_en pulses -> addr_up=1, wc_up=0, addr_en/wc_en=1 each pulse; done=1 the cycle after the pulse where wc_q==8'h01.
REQ-033 WRCR 8'h02, LDWC 8'h05 -> wc_data=8'h00 with wc_load; ENCT; done rises after the count where wc_q==8'h04.
REQ-034 WRCR 8'h07 (mode 11, down), LDAD 8'h00, LDWC 8'hFE -> wc_en stays 0; first count with addr_q==8'hFF is terminal; no count on 8'h00 wraps to done early.
REQ-035 ACTIVE, cnt_en and LDAD asserted same cycle -> addr_load=1, addr_en=0; then RDAC -> data_out=loaded value, data_oe=1 for one cycle.
REQ-036 In DONE, cnt_en pulses -> no enables; REINIT -> both loads asserted with stored values, done=0 next cycle.
